// File: rtl/bit_syn_pkg.sv
// bit_syn_pkg: shared defaults and legal stage-count bounds for the bit synchronizer.
package bit_syn_pkg;
  localparam int NO_S_DEFAULT      = 2;
  localparam int BUS_WIDTH_DEFAULT = 4;
  localparam int NO_S_MIN          = 2;
  localparam int NO_S_MAX          = 8;
endpackage

// File: rtl/bit_syn_chain.sv
// bit_syn_chain: one single-bit no_s-stage synchronizer chain with synchronous reset.
module bit_syn_chain
  import bit_syn_pkg::*;
#(
  parameter int no_s = NO_S_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  // Keep synthesis from retiming or merging the metastability-settling flops.
  (* ASYNC_REG = "TRUE" *) logic [no_s-1:0] stg;
  always_ff @(posedge clk)
    stg <= rst ? '0 : {stg[no_s-2:0], d};
  assign q = stg[no_s-1];
endmodule

// File: rtl/bit_syn.sv
// bit_syn: per-bit multi-flop synchronizer bus; BIT_SYN_PULSE_EN adds a registered rising-edge pulse per bit.
module bit_syn
  import bit_syn_pkg::*;
#(
  parameter int no_s      = NO_S_DEFAULT,
  parameter int bus_width = BUS_WIDTH_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [bus_width-1:0] ASYNC,
`ifdef BIT_SYN_PULSE_EN
  output logic [bus_width-1:0] SYNC_PULSE,
`endif
  output logic [bus_width-1:0] SYNC
);
  if (no_s < NO_S_MIN || no_s > NO_S_MAX || bus_width < 1) begin : g_bad_cfg
    $error("bit_syn: no_s must be %0d..%0d and bus_width >= 1", NO_S_MIN, NO_S_MAX);
  end
  for (genvar i = 0; i < bus_width; i++) begin : g_bit
    bit_syn_chain #(.no_s(no_s)) u_chain (
      .clk(CLK),
      .rst(RST),
      .d  (ASYNC[i]),
      .q  (SYNC[i])
    );
  end
`ifdef BIT_SYN_PULSE_EN
  logic [bus_width-1:0] prev;
  always_ff @(posedge CLK) begin
    prev       <= RST ? '0 : SYNC;
    SYNC_PULSE <= RST ? '0 : SYNC & ~prev;
  end
`endif
endmodule

// File: tb/tb_bit_syn.sv
// tb_bit_syn: scoreboard bench for bit_syn with no_s=2 and no_s=3 instances; pulse checks when BIT_SYN_PULSE_EN is defined.
module tb_bit_syn;
  typedef struct packed {
    logic       r;
    logic [3:0] a;
  } stim_t;

  logic       clk = 0;
  logic       rst = 1;
  logic [3:0] async_in = '0;
  logic [3:0] sync2, sync3;
  int         errors = 0;
  int         checks = 0;
  stim_t      hist[$];

  always #5 clk = ~clk;

`ifdef BIT_SYN_PULSE_EN
  logic [3:0] pulse2, pulse3;
  logic [3:0] e_prev = '0, e_pulse = '0, s_last = '0;
  bit_syn #(.no_s(2), .bus_width(4)) dut2 (.CLK(clk), .RST(rst), .ASYNC(async_in), .SYNC_PULSE(pulse2), .SYNC(sync2));
  bit_syn #(.no_s(3), .bus_width(4)) dut3 (.CLK(clk), .RST(rst), .ASYNC(async_in), .SYNC_PULSE(pulse3), .SYNC(sync3));
`else
  bit_syn #(.no_s(2), .bus_width(4)) dut2 (.CLK(clk), .RST(rst), .ASYNC(async_in), .SYNC(sync2));
  bit_syn #(.no_s(3), .bus_width(4)) dut3 (.CLK(clk), .RST(rst), .ASYNC(async_in), .SYNC(sync3));
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output after the current edge is the input from n edges back, unless any edge in that window was a reset.
  function automatic logic [3:0] exp_sync(input int n);
    exp_sync = hist[hist.size()-n].a;
    for (int k = hist.size() - n; k < hist.size(); k++)
      if (hist[k].r) exp_sync = '0;
  endfunction

  task automatic step(input logic r, input logic [3:0] a);
    rst = r;
    async_in = a;
    @(posedge clk);
    #1;
    hist.push_back({r, a});
    if (hist.size() > 3) hist = hist[1:$];
    if (hist.size() >= 2) check("sb_sync_n2", 32'(sync2), 32'(exp_sync(2)));
    if (hist.size() >= 3) check("sb_sync_n3", 32'(sync3), 32'(exp_sync(3)));
`ifdef BIT_SYN_PULSE_EN
    e_pulse = r ? '0 : s_last & ~e_prev;
    e_prev  = r ? '0 : s_last;
    s_last  = hist.size() >= 2 ? exp_sync(2) : '0;
    check("sb_pulse_n2", 32'(pulse2), 32'(e_pulse));
`endif
  endtask

  initial begin
    step(1, 4'b1101);
    step(1, 4'b1101);
    check("rst_n2", 32'(sync2), 32'h0);
    check("rst_n3", 32'(sync3), 32'h0);
    step(0, 4'b1101);
    check("rel1_n2", 32'(sync2), 32'h0);
    step(0, 4'b1101);
    check("rel2_n2", 32'(sync2), 32'hd);
    check("rel2_n3", 32'(sync3), 32'h0);
    step(0, 4'b1101);
    check("rel3_n3", 32'(sync3), 32'hd);
    repeat (4) step(0, 4'b0000);
    step(0, 4'b1010);
    check("lat_n3_e0", 32'(sync3), 32'h0);
    step(0, 4'b1010);
    check("lat_n3_e1", 32'(sync3), 32'h0);
    check("lat_n2_e1", 32'(sync2), 32'ha);
    step(0, 4'b1010);
    check("lat_n3_e2", 32'(sync3), 32'ha);
    repeat (4) step(0, 4'b1101);
    step(1, 4'b1101);
    check("midrst_n2", 32'(sync2), 32'h0);
    check("midrst_n3", 32'(sync3), 32'h0);
    step(0, 4'b1101);
    check("ret1_n2", 32'(sync2), 32'h0);
    step(0, 4'b1101);
    check("ret2_n2", 32'(sync2), 32'hd);
    step(0, 4'b1101);
    check("ret3_n3", 32'(sync3), 32'hd);
    for (int i = 0; i < 10; i++) begin
      step(0, {3'b110, i[1]});
      check("indep_n2", 32'(sync2[3:1]), 32'h6);
      check("indep_n3", 32'(sync3[3:1]), 32'h6);
    end
`ifdef BIT_SYN_PULSE_EN
    begin
      int rise_cnt = 0, fall_cnt = 0;
      repeat (4) step(0, 4'b0000);
      for (int i = 0; i < 6; i++) begin
        step(0, 4'b0100);
        if (pulse2 == 4'b0100) rise_cnt++;
      end
      check("pulse_once", 32'(rise_cnt), 32'd1);
      for (int i = 0; i < 6; i++) begin
        step(0, 4'b0000);
        if (pulse2 != 4'b0000) fall_cnt++;
      end
      check("pulse_fall", 32'(fall_cnt), 32'd0);
    end
`endif
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 15) == 0, 4'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bit_syn.md
BIT_SYN -- requirements
Module: bit_syn

Interface
REQ-001 Parameter no_s, default 2, number of synchronizer flip-flop stages per bit; legal range 2..8.
REQ-002 Parameter bus_width, default 4, number of independent single-bit signals synchronized.
REQ-003 CLK  input  1  destination-domain clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 ASYNC  input  bus_width  asynchronous inputs, one independent level signal per bit.
REQ-006 SYNC  output  bus_width  synchronized copy of ASYNC, driven directly from the last stage flop of each bit.
REQ-007 SYNC_PULSE  output  bus_width  per-bit rising-edge pulse; present only when BIT_SYN_PULSE_EN is defined.

Function
REQ-008 Each bit shall pass through its own chain of no_s flip-flops: stage 0 samples ASYNC[i], stage k samples stage k-1.
REQ-009 SYNC[i] shall equal the last stage of chain i, with no combinational logic between that flop and the port.
REQ-010 Latency: an ASYNC value meeting setup before rising edge n shall appear on SYNC after edge n+no_s-1, i.e. no_s edges counted from n inclusive.
REQ-011 Bits shall be fully independent; no cross-bit logic or ordering guarantee (bus coherency is not provided).
REQ-012 The block shall not filter, debounce or re-encode data; a level held for at least one period plus setup shall propagate unchanged.
REQ-013 A level shorter than one CLK period may be lost; no pulse-stretching shall be implemented.
REQ-014 The design shall reject no_s < 2 or bus_width < 1 at elaboration with an error.

Reset
REQ-015 While RST=1 at a rising edge, every stage flop of every bit shall load 0; SYNC shall read 0 after that edge.
REQ-016 RST=1 shall override ASYNC, including mid-propagation; in-flight values are discarded.
REQ-017 After RST falls, SYNC shall follow REQ-010, counting from the first edge with RST=0.
REQ-018 Before the first reset edge, SYNC is undefined; no initial-value assignment is required.

Configuration
REQ-019 Macro BIT_SYN_PULSE_EN: when defined, an extra flop per bit holds the previous SYNC[i], and SYNC_PULSE[i] = SYNC[i] AND NOT previous, registered, high for exactly one cycle per 0->1 transition of SYNC[i].
REQ-020 With BIT_SYN_PULSE_EN defined, the previous-value flop and SYNC_PULSE shall reset to 0, and a first post-reset SYNC of 1 shall produce a pulse.
REQ-021 Without BIT_SYN_PULSE_EN, the SYNC_PULSE port and its logic shall not exist; all other behaviour is identical.

Structure
REQ-022 Package bit_syn_pkg shall hold NO_S_DEFAULT=2, BUS_WIDTH_DEFAULT=4, NO_S_MIN=2 and NO_S_MAX=8.
REQ-023 Sub-module bit_syn_chain shall implement one single-bit no_s-stage chain with reset; bit_syn shall generate bus_width instances of it.
REQ-024 Stage flops shall carry the codebase's synchronizer attribute so that synthesis does not retime or merge them.

Verification
REQ-025 no_s=2, bus_width=4: RST=1 for 2 edges with ASYNC=4'b1101 -> SYNC=4'b0000.
REQ-026 Same setup, release RST -> SYNC=4'b0000 after the 1st edge and 4'b1101 after the 2nd edge with RST=0.
REQ-027 no_s=3: ASYNC changes 4'b0000->4'b1010 before edge n -> SYNC=4'b1010 after edge n+2 and not earlier.
REQ-028 SYNC=4'b1101 steady, assert RST for one edge -> SYNC=4'b0000 after that edge; return to 4'b1101 no_s edges after release.
REQ-029 Toggle ASYNC[0] only, ASYNC[3:1]=3'b110 held -> SYNC[3:1] stays 3'b110 while SYNC[0] tracks with no_s latency.
REQ-030 BIT_SYN_PULSE_EN defined: ASYNC[2] 0->1 held -> SYNC_PULSE=4'b0100 for exactly one cycle, one edge after SYNC[2] rises; a 1->0 change gives no pulse.
